// File: rtl/frag_byte_reader.sv
// Drains a byte-granular reassembly FIFO with 1..4 byte reads and re-emits the
// payload as header-prefixed fragments of at most FRAG_MAX bytes on a 32-bit stream.
module frag_byte_reader #(
   parameter int FRAG_MAX = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] pkt_len,
   output logic        busy,
   output logic        done,
   input  logic [4:0]  fifo_index,
   input  logic [31:0] fifo_dout,
   output logic        fifo_rd_en,
   output logic [3:0]  fifo_rd_bytes,
   output logic [31:0] m_data,
   output logic [2:0]  m_keep,
   output logic        m_last,
   output logic        m_valid,
   input  logic        m_ready
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DRAIN} state_t;

   localparam logic [15:0] FRAG_MAX_W = 16'(FRAG_MAX);

   state_t      state_q, state_d;
   logic [15:0] pkt_rem_q, pkt_rem_d;
   logic [15:0] frag_rem_q, frag_rem_d;
   logic [7:0]  seq_q, seq_d;
   logic        busy_q, busy_d;

   logic        inflight_q, inflight_d;
   logic [2:0]  tag_keep_q, tag_keep_d;
   logic        tag_last_q, tag_last_d;

   logic [31:0] qdata_q [2];
   logic [2:0]  qkeep_q [2];
   logic        qlast_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  count_q, count_d;

   logic        credit, hdr_fire, rd_fire, pop, last_read, lastfrag, hdr_ptr;
   logic [15:0] flen;
   logic [2:0]  n_bytes;
   logic [31:0] hdr_word;

   // Credit counts the queue before this cycle's pop, so a full queue never overflows.
   assign credit    = ({1'b0, count_q} + {2'b0, inflight_q}) < 3'd2;
   assign flen      = (pkt_rem_q > FRAG_MAX_W) ? FRAG_MAX_W : pkt_rem_q;
   assign lastfrag  = (pkt_rem_q == flen);
   assign hdr_word  = {seq_q, lastfrag, 7'd0, flen};
   assign n_bytes   = (frag_rem_q >= 16'd4) ? 3'd4 : frag_rem_q[2:0];
   assign last_read = (frag_rem_q == {13'd0, n_bytes});
   assign pop       = m_valid && m_ready;

   assign busy    = busy_q;
   assign m_valid = (count_q != 2'd0);
   assign m_data  = qdata_q[rd_ptr_q];
   assign m_keep  = qkeep_q[rd_ptr_q];
   assign m_last  = qlast_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pkt_rem_q  <= '0;
         frag_rem_q <= '0;
         seq_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pkt_rem_q  <= pkt_rem_d;
         frag_rem_q <= frag_rem_d;
         seq_q      <= seq_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pkt_rem_d  = pkt_rem_q;
      frag_rem_d = frag_rem_q;
      seq_d      = seq_q;
      busy_d     = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start && pkt_len != 16'd0) begin
               pkt_rem_d = pkt_len;
               seq_d     = '0;
               busy_d    = 1'b1;
               state_d   = S_HDR;
            end
         end
         S_HDR: begin
            if (hdr_fire) begin
               frag_rem_d = flen;
               pkt_rem_d  = pkt_rem_q - flen;
               state_d    = S_PAY;
            end
         end
         S_PAY: begin
            if (rd_fire) begin
               frag_rem_d = frag_rem_q - {13'd0, n_bytes};
               if (last_read) begin
                  if (pkt_rem_q != 16'd0) begin
                     state_d = S_HDR;
                     seq_d   = seq_q + 8'd1;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (!inflight_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hdr_fire      = 1'b0;
      rd_fire       = 1'b0;
      fifo_rd_en    = 1'b0;
      fifo_rd_bytes = 4'd0;
      done          = 1'b0;
      case (state_q)
         S_HDR:   hdr_fire = credit;
         S_PAY: begin
            if (credit && fifo_index >= {2'b00, n_bytes}) begin
               rd_fire       = 1'b1;
               fifo_rd_en    = 1'b1;
               fifo_rd_bytes = {1'b0, n_bytes};
            end
         end
         S_DRAIN: done = !inflight_q;
         default: ;
      endcase
   end

   // Keep/last of a read travel with it until its data lands next cycle.
   assign inflight_d = rd_fire;
   assign tag_keep_d = rd_fire ? n_bytes : tag_keep_q;
   assign tag_last_d = rd_fire ? last_read : tag_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         tag_keep_q <= '0;
         tag_last_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         tag_keep_q <= tag_keep_d;
         tag_last_q <= tag_last_d;
      end
   end

   // A landing word is older than a header pushed in the same cycle, so it takes the first slot.
   assign hdr_ptr = wr_ptr_q ^ inflight_q;
   assign count_d = count_q + {1'b0, inflight_q} + {1'b0, hdr_fire} - {1'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
         for (int i = 0; i < 2; i++) begin
            qdata_q[i] <= '0;
            qkeep_q[i] <= '0;
            qlast_q[i] <= 1'b0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_q ^ inflight_q ^ hdr_fire;
         rd_ptr_q <= rd_ptr_q ^ pop;
         count_q  <= count_d;
         for (int i = 0; i < 2; i++) begin
            if (inflight_q && wr_ptr_q == 1'(i)) begin
               qdata_q[i] <= fifo_dout;
               qkeep_q[i] <= tag_keep_q;
               qlast_q[i] <= tag_last_q;
            end else if (hdr_fire && hdr_ptr == 1'(i)) begin
               qdata_q[i] <= hdr_word;
               qkeep_q[i] <= 3'd4;
               qlast_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_frag_byte_reader.sv
// Directed bench for frag_byte_reader: byte-queue FIFO model, output collector,
// and one task per scenario comparing collected words against hand-built lists.
module tb_frag_byte_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] pkt_len = '0;
   logic        busy, done;
   logic [4:0]  fifo_index = '0;
   logic [31:0] fifo_dout = '0;
   logic        fifo_rd_en;
   logic [3:0]  fifo_rd_bytes;
   logic [31:0] m_data;
   logic [2:0]  m_keep;
   logic        m_last, m_valid;
   logic        m_ready = 1'b1;

   frag_byte_reader #(.FRAG_MAX(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pkt_len(pkt_len),
      .busy(busy), .done(done), .fifo_index(fifo_index), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_bytes(fifo_rd_bytes),
      .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   byte unsigned fifo_q[$];
   logic [35:0]  got_q[$];
   int           rd_log[$];
   logic         pend_en = 1'b0;
   int           pend_n = 0;
   int           done_count = 0, done_cycle = 0, last_rd_cycle = 0;
   int           stall_viol = 0, idx_viol = 0;
   logic         prev_stall = 1'b0;
   logic [35:0]  prev_word = '0;
   logic         toggle_en = 1'b0;

   // Observe everything mid-cycle, away from the active edge.
   always @(negedge clk) begin
      pend_en = rst_n && fifo_rd_en;
      pend_n  = int'(fifo_rd_bytes);
      if (rst_n) begin
         if (fifo_rd_en) begin
            rd_log.push_back(int'(fifo_rd_bytes));
            last_rd_cycle = cyc;
            if (fifo_rd_bytes > {1'b0, fifo_index} || fifo_rd_bytes == 4'd0 || fifo_rd_bytes > 4'd4)
               idx_viol++;
         end
         if (done) begin
            done_count++;
            done_cycle = cyc;
         end
         if (m_valid && m_ready) got_q.push_back({m_data, m_keep, m_last});
         if (prev_stall && {m_data, m_keep, m_last} !== prev_word) stall_viol++;
         prev_stall = m_valid && !m_ready;
         prev_word  = {m_data, m_keep, m_last};
      end else begin
         prev_stall = 1'b0;
      end
   end

   // FIFO model: a read accepted at this edge presents its bytes during the following cycle.
   always @(posedge clk) begin : fifo_model
      logic [31:0] w;
      cyc++;
      #1;
      if (pend_en) begin
         w = '0;
         for (int i = 0; i < pend_n; i++) begin
            if (fifo_q.size() > 0) w[31-8*i -: 8] = fifo_q.pop_front();
            else idx_viol++;
         end
         fifo_dout = w;
         pend_en = 1'b0;
      end
      fifo_index = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) m_ready = ~m_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_pkt(input logic [15:0] len);
      pkt_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      #1;
   endtask

   task automatic clear_logs();
      got_q.delete();
      rd_log.delete();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({m_valid, fifo_rd_en, busy, done, fifo_rd_bytes} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000000", {m_valid, fifo_rd_en, busy, done, fifo_rd_bytes});
      end
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if ({m_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 000", {m_valid, busy, done});
      end
   endtask

   task automatic test_basic();
      logic [35:0] exp_q[$];
      bit ok;
      clear_logs();
      for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
      tick();
      exp_q = '{{32'h0080_0008, 3'd4, 1'b0}, {32'h0102_0304, 3'd4, 1'b0}, {32'h0506_0708, 3'd4, 1'b1}};
      start_pkt(16'd8);
      wait_done(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL t1_done_timeout got none want done"); end
      checks++;
      if (done_cycle - last_rd_cycle !== 2) begin
         errors++;
         $display("FAIL t1_done_latency got %0d want 2", done_cycle - last_rd_cycle);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after_done got %b want 0", busy); end
      repeat (4) tick();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL t1_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t1_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 36'h0, exp_q[i]);
         end
      end
   endtask

   // 70-byte packet: a full 64-byte fragment then a 6-byte last fragment.
   task automatic test_two_frags(input bit toggle);
      logic [35:0] exp_q[$];
      bit ok;
      clear_logs();
      stall_viol = 0;
      for (int i = 1; i <= 70; i++) fifo_q.push_back(8'(i));
      exp_q.push_back({32'h0000_0040, 3'd4, 1'b0});
      for (int k = 0; k < 16; k++)
         exp_q.push_back({8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4), 3'd4, (k == 15)});
      exp_q.push_back({32'h0180_0006, 3'd4, 1'b0});
      exp_q.push_back({32'h4142_4344, 3'd4, 1'b0});
      exp_q.push_back({32'h4546_0000, 3'd2, 1'b1});
      tick();
      toggle_en = toggle;
      start_pkt(16'd70);
      wait_done(600, ok);
      repeat (8) tick();
      toggle_en = 1'b0;
      m_ready = 1'b1;
      tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL t2_done_timeout toggle=%0d got none want done", toggle); end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL t2_count toggle=%0d got %0d want %0d", toggle, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t2_word%0d toggle=%0d got %h want %h", i, toggle,
                     (i < got_q.size()) ? got_q[i] : 36'h0, exp_q[i]);
         end
      end
      checks++;
      if (stall_viol !== 0) begin errors++; $display("FAIL t2_stall_stable got %0d changes want 0", stall_viol); end
   endtask

   task automatic test_low_index();
      logic [35:0] exp_q[$];
      bit ok;
      clear_logs();
      fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
      tick();
      exp_q = '{{32'h0080_0005, 3'd4, 1'b0}, {32'hA1A2_A3A4, 3'd4, 1'b0}, {32'hA500_0000, 3'd1, 1'b1}};
      start_pkt(16'd5);
      repeat (10) tick();
      checks++;
      if (rd_log.size() !== 0) begin errors++; $display("FAIL t3_no_early_read got %0d reads want 0", rd_log.size()); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL t3_busy_stalled got %b want 1", busy); end
      fifo_q.push_back(8'hA3); fifo_q.push_back(8'hA4); fifo_q.push_back(8'hA5);
      wait_done(100, ok);
      repeat (4) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL t3_done_timeout got none want done"); end
      checks++;
      if (rd_log.size() !== 2 || rd_log[0] !== 4 || rd_log[1] !== 1) begin
         errors++;
         $display("FAIL t3_read_sizes got n=%0d first=%0d want 4 then 1", rd_log.size(),
                  (rd_log.size() > 0) ? rd_log[0] : -1);
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL t3_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t3_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 36'h0, exp_q[i]);
         end
      end
      checks++;
      if (idx_viol !== 0) begin errors++; $display("FAIL t3_rd_over_index got %0d want 0", idx_viol); end
   endtask

   task automatic test_reset_mid_packet();
      logic [35:0] exp_q[$];
      bit ok;
      bit seen;
      clear_logs();
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'hC0 + 8'(i));
      tick();
      start_pkt(16'd16);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (fifo_rd_en) seen = 1'b1;
      end
      @(posedge clk);
      #2;
      checks++;
      if (!seen || busy !== 1'b1) begin
         errors++; $display("FAIL t5_pre_reset got seen=%0d busy=%b want 1 1", seen, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_valid, fifo_rd_en, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL t5_async_reset got %b want 0000", {m_valid, fifo_rd_en, busy, done});
      end
      tick(); tick();
      fifo_q.delete();
      clear_logs();
      rst_n = 1'b1;
      tick();
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
      tick();
      exp_q = '{{32'h0080_0004, 3'd4, 1'b0}, {32'h1122_3344, 3'd4, 1'b1}};
      start_pkt(16'd4);
      wait_done(100, ok);
      repeat (4) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL t5_done_timeout got none want done"); end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL t5_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t5_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 36'h0, exp_q[i]);
         end
      end
   endtask

   task automatic test_ignored_starts();
      logic [35:0] exp_q[$];
      bit ok;
      int dc0;
      clear_logs();
      start_pkt(16'd0);
      repeat (4) tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL t6_zero_len_busy got %b want 0", busy); end
      checks++;
      if (got_q.size() !== 0) begin errors++; $display("FAIL t6_zero_len_words got %0d want 0", got_q.size()); end
      for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
      tick();
      exp_q = '{{32'h0080_0008, 3'd4, 1'b0}, {32'h1011_1213, 3'd4, 1'b0}, {32'h1415_1617, 3'd4, 1'b1}};
      dc0 = done_count;
      start_pkt(16'd8);
      tick();
      start_pkt(16'd20);
      wait_done(100, ok);
      repeat (8) tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL t6_done_timeout got none want done"); end
      checks++;
      if (done_count - dc0 !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL t6_single_done got dones=%0d busy=%b want 1 0", done_count - dc0, busy);
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL t6_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL t6_word%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 36'h0, exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_two_frags(1'b0);
      test_low_index();
      test_two_frags(1'b1);
      test_reset_mid_packet();
      test_ignored_starts();
      checks++;
      if (idx_viol !== 0) begin errors++; $display("FAIL rd_over_index_total got %0d want 0", idx_viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
